// File: rtl/btb_update_arb_if.sv
// ---------------------------------------------------------------------------
// btb_update_arb_if
//   Bundles the two-port branch-resolution update requests, the drain enable,
//   the BTB update port and the occupancy/perf outputs of btb_update_arb.
//
//   master : execute-stage / BTB side (drives requests and drain enable)
//   slave  : the arbiter (drives ready, BTB update port, count, perf counter)
//
//   req_valid_i[1:0]        per-port update request valid
//   req_ready_o[1:0]        per-port accept (valid & ready at a rising edge)
//   req_pc_i[1:0]           per-port branch PC
//   req_target_i[1:0]       per-port resolved target
//   req_taken_i[1:0]        per-port actual outcome
//   req_is_branch_i[1:0]    per-port conditional-branch flag (0 = jump)
//   drain_en_i              0 = hold FIFO contents, issue nothing
//   update_valid_o          BTB update_valid
//   update_pc_o             BTB update_pc
//   update_target_o         BTB update_target
//   update_taken_o          BTB update_taken
//   update_is_branch_o      BTB update_is_branch
//   fifo_count_o            current FIFO occupancy
//   issued_cnt_o            saturating count of issued updates
// ---------------------------------------------------------------------------
interface btb_update_arb_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic [1:0]             req_valid_i;
    logic [1:0]             req_ready_o;
    logic [1:0][31:0]       req_pc_i;
    logic [1:0][31:0]       req_target_i;
    logic [1:0]             req_taken_i;
    logic [1:0]             req_is_branch_i;
    logic                   drain_en_i;

    logic                   update_valid_o;
    logic [31:0]            update_pc_o;
    logic [31:0]            update_target_o;
    logic                   update_taken_o;
    logic                   update_is_branch_o;

    logic [$clog2(DEPTH):0] fifo_count_o;
    logic [CNT_W-1:0]       issued_cnt_o;

    modport master (
        output req_valid_i,
        output req_pc_i,
        output req_target_i,
        output req_taken_i,
        output req_is_branch_i,
        output drain_en_i,
        input  req_ready_o,
        input  update_valid_o,
        input  update_pc_o,
        input  update_target_o,
        input  update_taken_o,
        input  update_is_branch_o,
        input  fifo_count_o,
        input  issued_cnt_o
    );

    modport slave (
        input  req_valid_i,
        input  req_pc_i,
        input  req_target_i,
        input  req_taken_i,
        input  req_is_branch_i,
        input  drain_en_i,
        output req_ready_o,
        output update_valid_o,
        output update_pc_o,
        output update_target_o,
        output update_taken_o,
        output update_is_branch_o,
        output fifo_count_o,
        output issued_cnt_o
    );
endinterface

// File: rtl/btb_update_arb.sv
// ---------------------------------------------------------------------------
// btb_update_arb
//   Shares the single BTB update port between the branch ALU (port 0) and the
//   JALR/AGU unit (port 1). One request per cycle is accepted (round-robin on
//   contention) into a small in-order FIFO, which drains one entry per cycle
//   to the BTB while drain_en_i is high. A saturating counter tracks issued
//   updates for perf monitoring.
//
//   clk       clock
//   rst_n     synchronous active-low reset
//   bus       btb_update_arb_if.slave (request ports, drain enable, BTB
//             update port, fifo_count_o, issued_cnt_o)
//
//   DEPTH     FIFO entries, power of 2, >= 2
//   CNT_W     width of the issued-update counter
// ---------------------------------------------------------------------------
module btb_update_arb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    btb_update_arb_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_branch;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             rr_pri_q, rr_pri_d;
    logic             accept_en_q, accept_en_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    logic [1:0]       grant;
    logic             space;
    logic             enq;
    logic             pop;
    logic             sel;
    entry_t           wr_entry;
    entry_t           head;

    // Arbitration. Space is judged on the registered occupancy only, so a
    // full FIFO refuses requests even in a cycle where it also pops.
    // accept_en_q keeps ready low for the first cycle after reset.
    always_comb begin
        space = (count_q < OCC_W'(DEPTH));
        grant = 2'b00;
        if (space && rst_n && accept_en_q) begin
            case (bus.req_valid_i)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_pri_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign enq = |grant;
    assign sel = grant[1];

    always_comb begin
        wr_entry.pc        = bus.req_pc_i[sel];
        wr_entry.target    = bus.req_target_i[sel];
        wr_entry.taken     = bus.req_taken_i[sel];
        wr_entry.is_branch = bus.req_is_branch_i[sel];
    end

    // The BTB accepts every cycle, so a presented update is also a pop.
    assign head = fifo_q[rd_ptr_q];
    assign pop  = rst_n && (count_q != '0) && bus.drain_en_i;

    assign bus.req_ready_o        = grant;
    assign bus.update_valid_o     = pop;
    assign bus.update_pc_o        = head.pc;
    assign bus.update_target_o    = head.target;
    assign bus.update_taken_o     = head.taken;
    assign bus.update_is_branch_o = head.is_branch;
    assign bus.fifo_count_o       = count_q;
    assign bus.issued_cnt_o       = issued_q;

    always_comb begin
        fifo_d = fifo_q;
        if (enq) begin
            fifo_d[wr_ptr_q] = wr_entry;
        end

        // Pointers wrap naturally because DEPTH is a power of 2.
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        case ({enq, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        rr_pri_d = enq ? ~sel : rr_pri_q;

        issued_d = issued_q;
        if (pop && (issued_q != {CNT_W{1'b1}})) begin
            issued_d = issued_q + CNT_W'(1);
        end

        accept_en_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_pri_q    <= 1'b0;
            accept_en_q <= 1'b0;
            issued_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_pri_q    <= rr_pri_d;
            accept_en_q <= accept_en_d;
            issued_q    <= issued_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
